// File: rtl/tetris_pkg.sv
// Board geometry, colour encoding and address helpers shared by the
// collision reader and the piece writer.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned COL_W   = 6;

  localparam logic [COL_W-1:0] COL_BLACK = '0;

  typedef enum logic [1:0] {
    PW_IDLE,
    PW_WRITE,
    PW_SCAN,
    PW_DONE
  } pw_state_e;

  // 9-bit coordinates so callers can pass unwrapped sums; result is 8-bit.
  function automatic logic [7:0] board_addr(input logic [8:0] x, input logic [8:0] y);
    logic [15:0] a;
    a = ({7'd0, y} * 16'(BOARD_W)) + {7'd0, x};
    return a[7:0];
  endfunction

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[i] && !found) begin
        r     = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piece_writer_row_scanner.sv
// Reads one board row (cols 0..9) and reports whether every cell is non-black.
// start is held high for the whole 11-cycle visit; row must stay stable.
module row_scanner
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       row,
  input  logic [COL_W-1:0] ram_Q,
  output logic [7:0]       addr,
  output logic             full,
  output logic             ready
);

  logic [3:0] col_q, col_d;
  logic [3:0] cnt_q, cnt_d;
  logic       q_hit;

  always_comb begin
    q_hit = (ram_Q != COL_BLACK);
    col_d = col_q;
    cnt_d = cnt_q;
    ready = 1'b0;
    full  = 1'b0;
    addr  = board_addr({5'd0, col_q}, {2'd0, row});
    if (start) begin
      // col_q == BOARD_W is the drain cycle: Q holds the column-9 read.
      if (col_q == 4'(BOARD_W)) begin
        ready = 1'b1;
        full  = ((cnt_q + {3'd0, q_hit}) == 4'(BOARD_W));
        col_d = '0;
        cnt_d = '0;
      end else begin
        col_d = col_q + 4'd1;
        if (col_q != 4'd0) begin
          cnt_d = cnt_q + {3'd0, q_hit};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piece_writer.sv
// Writes (or erases) a tetromino into the board RAM, then checks the rows the
// locked piece touched for completeness.
module piece_writer
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             erase,
  input  logic [7:0]       X,
  input  logic [6:0]       Y,
  input  logic [15:0]      cells,
  input  logic [COL_W-1:0] colour,
  input  logic [COL_W-1:0] ram_Q,
  output logic [7:0]       ram_addr,
  output logic [COL_W-1:0] ram_data,
  output logic             ram_wren,
  output logic             busy,
  output logic             done,
  output logic [3:0]       full_rows,
  output logic             oob
);

  pw_state_e        state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [15:0]      cells_q, cells_d;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             erase_q, erase_d;
  logic [1:0]       cell_q, cell_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       full_q, full_d;
  logic             oob_q, oob_d;

  logic [3:0] cur;
  logic [8:0] cell_x, cell_y;
  logic       cell_oob;
  logic [3:0] mask_acc, mask_rem;
  logic       scan_en, scan_full, scan_ready;
  logic [6:0] scan_row;
  logic [7:0] scan_addr;

  row_scanner u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_en),
    .row   (scan_row),
    .ram_Q (ram_Q),
    .addr  (scan_addr),
    .full  (scan_full),
    .ready (scan_ready)
  );

  assign scan_en   = (state_q == PW_SCAN);
  assign scan_row  = y_q + {5'd0, row_q};
  assign full_rows = full_q;
  assign oob       = oob_q;

  always_comb begin
    cur      = cells_q[4*cell_q +: 4];
    cell_x   = {1'b0, x_q} + {7'd0, cur[3:2]};
    cell_y   = {2'b0, y_q} + {7'd0, cur[1:0]};
    cell_oob = (cell_x > 9'(BOARD_W - 1)) || (cell_y > 9'(BOARD_H - 1));
    mask_acc = mask_q | (cell_oob ? 4'b0000 : (4'b0001 << cur[1:0]));
    mask_rem = mask_q & ~(4'b0001 << row_q);

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cells_d  = cells_q;
    colour_d = colour_q;
    erase_d  = erase_q;
    cell_d   = cell_q;
    row_d    = row_q;
    mask_d   = mask_q;
    full_d   = full_q;
    oob_d    = oob_q;
    ram_addr = '0;
    ram_data = COL_BLACK;
    ram_wren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      PW_IDLE: begin
        if (start) begin
          x_d      = X;
          y_d      = Y;
          cells_d  = cells;
          colour_d = colour;
          erase_d  = erase;
          cell_d   = '0;
          mask_d   = '0;
          full_d   = '0;
          oob_d    = 1'b0;
          state_d  = PW_WRITE;
        end
      end
      PW_WRITE: begin
        busy     = 1'b1;
        ram_addr = board_addr(cell_x, cell_y);
        ram_data = erase_q ? COL_BLACK : colour_q;
        ram_wren = !cell_oob;
        if (cell_oob) oob_d = 1'b1;
        mask_d = mask_acc;
        cell_d = cell_q + 2'd1;
        if (cell_q == 2'd3) begin
          // A lock whose cells all fell off has no rows to check.
          if (erase_q || (mask_acc == 4'b0000)) begin
            state_d = PW_DONE;
          end else begin
            row_d   = lowest_bit(mask_acc);
            state_d = PW_SCAN;
          end
        end
      end
      PW_SCAN: begin
        busy     = 1'b1;
        ram_addr = scan_addr;
        if (scan_ready) begin
          full_d[row_q] = scan_full;
          mask_d        = mask_rem;
          row_d         = lowest_bit(mask_rem);
          if (mask_rem == 4'b0000) state_d = PW_DONE;
        end
      end
      PW_DONE: begin
        done    = 1'b1;
        state_d = PW_IDLE;
      end
      default: state_d = PW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PW_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cells_q  <= '0;
      colour_q <= '0;
      erase_q  <= 1'b0;
      cell_q   <= '0;
      row_q    <= '0;
      mask_q   <= '0;
      full_q   <= '0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cells_q  <= cells_d;
      colour_q <= colour_d;
      erase_q  <= erase_d;
      cell_q   <= cell_d;
      row_q    <= row_d;
      mask_q   <= mask_d;
      full_q   <= full_d;
      oob_q    <= oob_d;
    end
  end

endmodule

// File: tb/tb_piece_writer.sv
// Bench for piece_writer: 256x6 registered-read RAM, board reference model,
// directed scenarios followed by randomized locks and erases.
module tb_piece_writer;

  logic        clk = 1'b0;
  logic        reset, start, erase;
  logic [7:0]  X;
  logic [6:0]  Y;
  logic [15:0] cells;
  logic [5:0]  colour, ram_Q;
  logic [7:0]  ram_addr;
  logic [5:0]  ram_data;
  logic        ram_wren, busy, done, oob;
  logic [3:0]  full_rows;

  int errors = 0;
  int checks = 0;

  logic [5:0]  mem   [0:255];
  logic [5:0]  board [0:199];
  logic [13:0] obs_q [$];
  logic [13:0] exp_q [$];
  int          exp_lat;
  logic [3:0]  exp_full;
  logic        exp_oob;

  logic        bd_clear = 1'b0;
  logic        bd_we    = 1'b0;
  logic [7:0]  bd_addr  = '0;
  logic [5:0]  bd_data  = '0;

  piece_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .erase     (erase),
    .X         (X),
    .Y         (Y),
    .cells     (cells),
    .colour    (colour),
    .ram_Q     (ram_Q),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .busy      (busy),
    .done      (done),
    .full_rows (full_rows),
    .oob       (oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
      obs_q.push_back({ram_addr, ram_data});
    end
    ram_Q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic poke(input int a, input logic [5:0] v);
    bd_we = 1'b1; bd_addr = 8'(a); bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    board[a] = v;
  endtask

  // Expected effect of one operation, straight from the board rules.
  task automatic model_op(input int x, input int y, input logic [15:0] c,
                          input logic [5:0] col, input logic er);
    int dx, dy, cx, cy, a, rows, n;
    logic [3:0] mask;
    exp_q.delete();
    mask = '0; exp_oob = 1'b0; exp_full = '0; rows = 0;
    for (int i = 0; i < 4; i++) begin
      dx = int'(c[4*i+2 +: 2]);
      dy = int'(c[4*i +: 2]);
      cx = x + dx;
      cy = y + dy;
      if (cx > 9 || cy > 19) begin
        exp_oob = 1'b1;
      end else begin
        a = cy * 10 + cx;
        board[a] = er ? 6'd0 : col;
        exp_q.push_back({8'(a), er ? 6'd0 : col});
        mask[dy] = 1'b1;
      end
    end
    if (!er) begin
      for (int r = 0; r < 4; r++) begin
        if (mask[r]) begin
          rows++;
          n = 0;
          for (int k = 0; k < 10; k++) if (board[(y + r) * 10 + k] != 6'd0) n++;
          exp_full[r] = (n == 10);
        end
      end
    end
    exp_lat = 4 + 11 * rows + 1;
  endtask

  task automatic compare_ram(input string tag);
    int mism;
    mism = 0;
    for (int a = 0; a < 200; a++) if (mem[a] !== board[a]) mism++;
    check({tag, ".ram"}, mism, 0);
  endtask

  task automatic run_op(input string tag, input int x, input int y, input logic [15:0] c,
                        input logic [5:0] col, input logic er,
                        input logic pulse_mid, input logic pulse_done);
    int n, base, dones;
    model_op(x, y, c, col, er);
    base = obs_q.size();
    X = 8'(x); Y = 7'(y); cells = c; colour = col; erase = er; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    n = 1;
    while (!done && n < 400) begin
      start = pulse_mid && (n == 3);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_at_done"}, busy, 0);
    check({tag, ".full_rows"}, full_rows, exp_full);
    check({tag, ".oob"}, oob, exp_oob);
    check({tag, ".nwrites"}, obs_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < obs_q.size()) check({tag, ".write"}, obs_q[base + k], exp_q[k]);
    start = pulse_done;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    check({tag, ".idle_after"}, dones, 0);
    check({tag, ".full_hold"}, full_rows, exp_full);
    check({tag, ".oob_hold"}, oob, exp_oob);
    compare_ram(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; erase = 1'b0; X = '0; Y = '0; cells = '0; colour = '0;
    bd_clear = 1'b1;
    for (int a = 0; a < 200; a++) board[a] = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    bd_clear = 1'b0;
    reset = 1'b0;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.wren", ram_wren, 0);
    check("reset.addr", ram_addr, 0);
    check("reset.data", ram_data, 0);
    check("reset.full_rows", full_rows, 0);
    check("reset.oob", oob, 0);

    // O-piece at the bottom of an empty board: two rows scanned.
    run_op("lock_o", 4, 18, 16'h5140, 6'h2A, 1'b0, 1'b0, 1'b0);
    check("lock_o.lat27", exp_lat, 27);

    // Row 19 pre-filled apart from cols 6..7; the O-piece completes it.
    for (int k = 0; k < 10; k++) if (k != 6 && k != 7) poke(190 + k, 6'(k + 1));
    run_op("fill_row", 6, 18, 16'h5140, 6'h15, 1'b0, 1'b0, 1'b0);

    run_op("erase_o", 4, 18, 16'h5140, 6'h2A, 1'b1, 1'b0, 1'b0);
    run_op("oob_x", 9, 5, 16'h2140, 6'h07, 1'b0, 1'b0, 1'b0);
    run_op("oob_all", 9, 19, 16'hFFFF, 6'h09, 1'b0, 1'b0, 1'b0);
    run_op("ignored_start", 2, 10, 16'h3210, 6'h33, 1'b0, 1'b1, 1'b1);

    // Reset while the scanner is mid-row.
    model_op(0, 10, 16'h5140, 6'h11, 1'b0);
    X = 8'd0; Y = 7'd10; cells = 16'h5140; colour = 6'h11; erase = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("mid_reset.in_scan", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset.busy", busy, 0);
    check("mid_reset.wren", ram_wren, 0);
    check("mid_reset.full_rows", full_rows, 0);
    check("mid_reset.done", done, 0);
    compare_ram("mid_reset");

    for (int t = 0; t < 12; t++) begin
      run_op("rand", int'($urandom_range(0, 10)), int'($urandom_range(0, 20)),
             16'($urandom), 6'($urandom_range(1, 63)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
